// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the data-memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  // State codes double as the grant code driven on oGrant.
  localparam arb_state_t ST_IDLE    = 2'b00;
  localparam arb_state_t ST_OWN_CPU = 2'b01;
  localparam arb_state_t ST_OWN_AUX = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_AUX  = 2'b10;

  localparam int unsigned AGE_MAX_DEFAULT = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM controller.
// slave  : arbiter view
// master : environment view (CPU datapath, aux master and memory slave)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              iCpuReq;
  logic              iCpuWE;
  logic [ADDR_W-1:0] iCpuAddr;
  logic [DATA_W-1:0] iCpuWData;
  logic [BE_W-1:0]   iCpuBE;
  logic [DATA_W-1:0] oCpuRData;
  logic              oCpuAck;
  logic              oCpuStall;

  logic              iAuxReq;
  logic              iAuxWE;
  logic              iAuxLock;
  logic [ADDR_W-1:0] iAuxAddr;
  logic [DATA_W-1:0] iAuxWData;
  logic [BE_W-1:0]   iAuxBE;
  logic [DATA_W-1:0] oAuxRData;
  logic              oAuxAck;

  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic [BE_W-1:0]   oMemBE;
  logic              oMemWE;
  logic              oMemRE;
  logic [DATA_W-1:0] iMemRData;
  logic              iMemReady;

  logic [1:0]        oGrant;

  modport slave (
    input  iCpuReq, iCpuWE, iCpuAddr, iCpuWData, iCpuBE,
    output oCpuRData, oCpuAck, oCpuStall,
    input  iAuxReq, iAuxWE, iAuxLock, iAuxAddr, iAuxWData, iAuxBE,
    output oAuxRData, oAuxAck,
    output oMemAddr, oMemWData, oMemBE, oMemWE, oMemRE,
    input  iMemRData, iMemReady,
    output oGrant
  );

  modport master (
    output iCpuReq, iCpuWE, iCpuAddr, iCpuWData, iCpuBE,
    input  oCpuRData, oCpuAck, oCpuStall,
    output iAuxReq, iAuxWE, iAuxLock, iAuxAddr, iAuxWData, iAuxBE,
    input  oAuxRData, oAuxAck,
    input  oMemAddr, oMemWData, oMemBE, oMemWE, oMemRE,
    output iMemRData, iMemReady,
    input  oGrant
  );

endinterface

// File: rtl/mem_bus_arbiter_age_counter.sv
// Saturating 8-bit event counter with a threshold flag; used for aux aging
// and for bounding locked aux bursts while the CPU waits.
module arb_age_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic inc_i,
  input  logic clr_i,
  output logic reached_o
);
  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q, cnt_d;

  // Clear dominates increment; count sticks at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign reached_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the core's data-memory bus: CPU has fixed priority,
// a waiting aux master wins once it has aged, and aux may lock the bus.
//
// state      | meaning
// ST_IDLE    | no owner; memory outputs parked at 0; arbitration decided here
// ST_OWN_CPU | CPU fields drive the memory bus until iMemReady
// ST_OWN_AUX | aux fields drive the memory bus; iAuxLock can extend ownership
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AGE_MAX = AGE_MAX_DEFAULT
) (
  input  logic             iCLK,
  input  logic             iRST,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic       own_cpu, own_aux, cpu_done, aux_done;
  logic       age_hit, lock_hit;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_we, mem_re;

  assign own_cpu  = (state_q == ST_OWN_CPU);
  assign own_aux  = (state_q == ST_OWN_AUX);
  assign cpu_done = own_cpu & bus.iMemReady;
  assign aux_done = own_aux & bus.iMemReady;

  // Aux aging: counts cycles aux waits, restarts once aux wins the bus.
  arb_age_counter #(.LIMIT(AGE_MAX)) u_age (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .inc_i     (bus.iAuxReq & ~own_aux),
    .clr_i     (~own_aux & (state_d == ST_OWN_AUX)),
    .reached_o (age_hit)
  );

  // Lock burst length: aux completions in the current tenure. A waiting CPU
  // lets the lock cover at most AGE_MAX transactions, so the flag trips one
  // early and the AGE_MAX-th completion hands the bus back.
  arb_age_counter #(.LIMIT(AGE_MAX - 1)) u_lock (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .inc_i     (aux_done),
    .clr_i     (own_aux & (state_d != ST_OWN_AUX)),
    .reached_o (lock_hit)
  );

  // Next-state: priority/aging in IDLE, release on completion unless locked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iCpuReq && bus.iAuxReq) state_d = age_hit ? ST_OWN_AUX : ST_OWN_CPU;
        else if (bus.iCpuReq)           state_d = ST_OWN_CPU;
        else if (bus.iAuxReq)           state_d = ST_OWN_AUX;
      end
      ST_OWN_CPU: begin
        if (bus.iMemReady) state_d = ST_IDLE;
      end
      ST_OWN_AUX: begin
        if (bus.iMemReady) begin
          if (bus.iAuxLock && (!bus.iCpuReq || !lock_hit)) state_d = ST_OWN_AUX;
          else                                             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; async reset abandons any transaction in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Memory-side mux: owner's fields pass straight through, zeros in IDLE.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (own_cpu) begin
      mem_addr  = bus.iCpuAddr;
      mem_wdata = bus.iCpuWData;
      mem_be    = bus.iCpuBE;
      mem_we    = bus.iCpuWE;
      mem_re    = ~bus.iCpuWE;
    end else if (own_aux) begin
      mem_addr  = bus.iAuxAddr;
      mem_wdata = bus.iAuxWData;
      mem_be    = bus.iAuxBE;
      mem_we    = bus.iAuxWE;
      mem_re    = ~bus.iAuxWE;
    end
  end

  assign bus.oMemAddr  = mem_addr;
  assign bus.oMemWData = mem_wdata;
  assign bus.oMemBE    = mem_be;
  assign bus.oMemWE    = mem_we;
  assign bus.oMemRE    = mem_re;

  assign bus.oCpuAck   = cpu_done;
  assign bus.oAuxAck   = aux_done;
  assign bus.oCpuRData = own_cpu ? bus.iMemRData : '0;
  assign bus.oAuxRData = own_aux ? bus.iMemRData : '0;
  // Reset forces every output low, including the stall that would otherwise
  // follow a held iCpuReq.
  assign bus.oCpuStall = bus.iCpuReq & ~cpu_done & ~iRST;
  assign bus.oGrant    = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AGE = 4;

  logic clk;
  logic rst;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .AGE_MAX(AGE)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        aux_req;
    logic        aux_we;
    logic        aux_lock;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [3:0]  aux_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } in_t;

  typedef struct packed {
    logic [1:0]  grant;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        cpu_ack;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        aux_ack;
    logic [31:0] aux_rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic in_t in_cpu(logic we, logic [31:0] addr, logic [31:0] wd,
                                 logic [3:0] be, logic [31:0] rd, logic rdy);
    in_t t;
    t = '0;
    t.cpu_req = 1'b1; t.cpu_we = we; t.cpu_addr = addr; t.cpu_wdata = wd; t.cpu_be = be;
    t.mem_rdata = rd; t.mem_ready = rdy;
    return t;
  endfunction

  function automatic in_t in_aux(logic we, logic lock, logic [31:0] addr, logic [31:0] wd,
                                 logic [3:0] be, logic [31:0] rd, logic rdy);
    in_t t;
    t = '0;
    t.aux_req = 1'b1; t.aux_we = we; t.aux_lock = lock; t.aux_addr = addr;
    t.aux_wdata = wd; t.aux_be = be;
    t.mem_rdata = rd; t.mem_ready = rdy;
    return t;
  endfunction

  function automatic out_t o_idle(logic stall);
    out_t o;
    o = '0;
    o.cpu_stall = stall;
    return o;
  endfunction

  function automatic out_t o_cpu(logic we, logic [31:0] addr, logic [31:0] wd,
                                 logic [3:0] be, logic ack, logic [31:0] rd);
    out_t o;
    o = '0;
    o.grant = 2'b01; o.mem_re = ~we; o.mem_we = we;
    o.mem_addr = addr; o.mem_wdata = wd; o.mem_be = be;
    o.cpu_ack = ack; o.cpu_rdata = rd; o.cpu_stall = ~ack;
    return o;
  endfunction

  function automatic out_t o_aux(logic we, logic [31:0] addr, logic [31:0] wd,
                                 logic [3:0] be, logic ack, logic [31:0] rd);
    out_t o;
    o = '0;
    o.grant = 2'b10; o.mem_re = ~we; o.mem_we = we;
    o.mem_addr = addr; o.mem_wdata = wd; o.mem_be = be;
    o.aux_ack = ack; o.aux_rdata = rd;
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.grant     = bus.oGrant;
    o.mem_re    = bus.oMemRE;
    o.mem_we    = bus.oMemWE;
    o.mem_addr  = bus.oMemAddr;
    o.mem_wdata = bus.oMemWData;
    o.mem_be    = bus.oMemBE;
    o.cpu_ack   = bus.oCpuAck;
    o.cpu_stall = bus.oCpuStall;
    o.cpu_rdata = bus.oCpuRData;
    o.aux_ack   = bus.oAuxAck;
    o.aux_rdata = bus.oAuxRData;
    return o;
  endfunction

  task automatic drive(input in_t t);
    bus.iCpuReq   = t.cpu_req;
    bus.iCpuWE    = t.cpu_we;
    bus.iCpuAddr  = t.cpu_addr;
    bus.iCpuWData = t.cpu_wdata;
    bus.iCpuBE    = t.cpu_be;
    bus.iAuxReq   = t.aux_req;
    bus.iAuxWE    = t.aux_we;
    bus.iAuxLock  = t.aux_lock;
    bus.iAuxAddr  = t.aux_addr;
    bus.iAuxWData = t.aux_wdata;
    bus.iAuxBE    = t.aux_be;
    bus.iMemRData = t.mem_rdata;
    bus.iMemReady = t.mem_ready;
  endtask

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock: drive just after posedge, compare at negedge.
  task automatic step(input in_t vi, input out_t vo, input string nm);
    drive(vi);
    @(negedge clk);
    chk_out(nm, get_out(), vo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_t       t;
    in_t       lc;
    logic [1:0] cexp [12];
    int        acks;
    logic      got;

    // Cycle-by-cycle directed table; state carries over between rows.
    t = in_cpu(1'b0, 32'h1000_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    vecs[0]  = '{t, o_idle(1'b1)};
    vecs[1]  = '{t, o_cpu(1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF)};
    vecs[2]  = '{in_t'('0), o_idle(1'b0)};
    t = in_aux(1'b1, 1'b0, 32'h2000_0010, 32'h1234_5678, 4'b0011, 32'h0, 1'b0);
    vecs[3]  = '{t, o_idle(1'b0)};
    vecs[4]  = '{t, o_aux(1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 1'b0, 32'h0)};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    t = in_aux(1'b1, 1'b0, 32'h2000_0010, 32'h1234_5678, 4'b0011, 32'hCAFE_F00D, 1'b1);
    vecs[7]  = '{t, o_aux(1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 1'b1, 32'hCAFE_F00D)};
    t = '0; t.mem_ready = 1'b1; t.mem_rdata = 32'h7777_7777;
    vecs[8]  = '{t, o_idle(1'b0)};
    t = in_cpu(1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'hF, 32'h1111_1111, 1'b1);
    vecs[9]  = '{t, o_idle(1'b1)};
    vecs[10] = '{t, o_cpu(1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h1111_1111)};
    vecs[11] = vecs[9];
    vecs[12] = vecs[10];
    vecs[13] = '{in_t'('0), o_idle(1'b0)};
    t = in_cpu(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hBBBB_0000, 1'b1);
    t.aux_req = 1'b1; t.aux_addr = 32'h0000_0044; t.aux_be = 4'hF;
    vecs[14] = '{t, o_idle(1'b1)};
    vecs[15] = '{t, o_cpu(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b1, 32'hBBBB_0000)};
    t = in_aux(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 32'hAAAA_0000, 1'b1);
    vecs[16] = '{t, o_idle(1'b0)};
    vecs[17] = '{t, o_aux(1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b1, 32'hAAAA_0000)};
    vecs[18] = '{in_t'('0), o_idle(1'b0)};

    cexp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};

    rst = 1'b1;
    drive('0);
    #2;
    chk_out("reset_state", get_out(), o_idle(1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));
    end

    // Contention: both request every cycle, memory always ready.
    t = in_cpu(1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h0, 1'b1);
    t.aux_req = 1'b1; t.aux_addr = 32'h0000_0054; t.aux_be = 4'hF;
    for (int c = 0; c < 12; c++) begin
      drive(t);
      @(negedge clk);
      chk_val($sformatf("contention_grant_c%0d", c), {30'b0, bus.oGrant}, {30'b0, cexp[c]});
      @(posedge clk);
      #1;
    end
    step('0, o_idle(1'b0), "contention_drain");

    // Locked aux burst with CPU idle: one ack per cycle.
    t = in_aux(1'b1, 1'b1, 32'h0000_0060, 32'h0000_0600, 4'hF, 32'h0, 1'b1);
    step(t, o_idle(1'b0), "lock_l0");
    for (int b = 1; b <= 3; b++) begin
      step(t, o_aux(1'b1, 32'h0000_0060, 32'h0000_0600, 4'hF, 1'b1, 32'h0),
           $sformatf("lock_l%0d", b));
    end

    // CPU now requests; lock must yield within AGE aux transactions.
    lc = t;
    lc.cpu_req = 1'b1; lc.cpu_addr = 32'h0000_0070; lc.cpu_be = 4'hF;
    acks = 0;
    got  = 1'b0;
    for (int c = 0; c < 4 * AGE && !got; c++) begin
      drive(lc);
      @(negedge clk);
      if (bus.oGrant == 2'b01) begin
        got = 1'b1;
        chk_val("lock_cpu_ack_on_grant", {31'b0, bus.oCpuAck}, 32'd1);
      end else if (bus.oAuxAck) begin
        acks++;
      end
      @(posedge clk);
      #1;
    end
    chk_val("lock_cpu_granted", {31'b0, got}, 32'd1);
    chk_val("lock_aux_acks_bounded", {31'b0, (acks <= AGE)}, 32'd1);
    step('0, o_idle(1'b0), "lock_drain");

    // Async reset in the middle of a stalled CPU access.
    t = in_cpu(1'b0, 32'h0000_0080, 32'h0, 4'hF, 32'h0, 1'b0);
    step(t, o_idle(1'b1), "rst_r0");
    drive(t);
    @(negedge clk);
    chk_out("rst_r1_owned", get_out(), o_cpu(1'b0, 32'h0000_0080, 32'h0, 4'hF, 1'b0, 32'h0));
    #1;
    bus.iMemReady = 1'b1;
    bus.iMemRData = 32'h0000_0099;
    rst = 1'b1;
    #1;
    chk_out("rst_async_zero", get_out(), o_idle(1'b0));
    @(posedge clk);
    #1;
    chk_out("rst_held_zero", get_out(), o_idle(1'b0));
    rst = 1'b0;
    t = in_cpu(1'b0, 32'h0000_0080, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b1);
    step(t, o_idle(1'b1), "rst_after_idle");
    step(t, o_cpu(1'b0, 32'h0000_0080, 32'h0, 4'hF, 1'b1, 32'h5A5A_5A5A), "rst_after_ack");
    step('0, o_idle(1'b0), "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
